simple_lsu: RTL and testbench
=============================

Name: simple_lsu

Overview:
- Load/store unit between the core's memory stage and the byte-addressed data memory.
- Accepts one RISC-V load/store request per transaction over a valid/ready handshake.
- Checks alignment, range and funct3; drives the memory read address, write address, write data and byte strobes.
- Sign- or zero-extends load data and returns a registered response with a fault flag.

Parameters:
pMemBytes, 32'd512, memory size in bytes; highest legal byte address = pMemBytes-1.

Ports:
iwClk  in  1  clock; all state updates on posedge.
iwnRst  in  1  reset, asynchronous, active-low.
iwReqValid  in  1  request valid.
owReqReady  out  1  LSU can accept a request (state IDLE).
iwReqWrite  in  1  1 = store, 0 = load.
iwReqFunct3  in  3  RV32I funct3: LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2.
iwReqAddr  in  32  byte address.
iwReqWdata  in  32  store data, low-aligned.
owRespValid  out  1  response valid (state RESP).
iwRespReady  in  1  core accepts the response.
owRespRdata  out  32  extended load data; 0 for stores and faults.
owRespFault  out  1  misaligned, out-of-range or illegal funct3.
owMemReadAddr  out  32  memory read address (latched request address).
iwMemReadData  in  32  memory read data; byte 0 = addressed byte; combinational.
owMemWriteAddr  out  32  memory write address (latched request address).
owMemWriteData  out  32  latched store data.
owMemWstrb  out  4  byte strobes; memory commits on the negedge of the ACCESS cycle.

Behaviour:
- Reset (async, iwnRst low):
  - state=IDLE; all latched registers = 0.
  - owRespValid=0, owRespRdata=0, owRespFault=0, owMemWstrb=0.
  - owReqReady=1 once state is IDLE.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - owReqReady=1.
  - On iwReqValid, latch write, funct3, addr and wdata.
  - Compute size: funct3[1:0] 0→1, 1→2, 2→4.
  - Fault if any of:
    - funct3 illegal: loads 3/6/7; stores 3–7.
    - addr[0]≠0 when size≥2, or addr[1:0]≠0 when size=4.
    - addr+size > pMemBytes (compute in 33 bits so wrap-around is detected).
  - Fault → RESP with fault=1, rdata=0; no memory access and no strobes.
  - Otherwise → ACCESS.
- ACCESS (exactly one cycle):
  - owMemWstrb = SB 0001, SH 0011, SW 1111 for stores; 0000 for loads.
  - Strobes are decoded only from registered state, so they are glitch-free through the negedge.
  - Loads: capture iwMemReadData at the posedge ending ACCESS into owRespRdata.
    - LB/LBU: extend bit 7 (sign) or zero-fill.
    - LH/LHU: extend bit 15 (sign) or zero-fill.
    - LW: pass through.
  - Stores: rdata=0.
  - → RESP.
- RESP:
  - owRespValid=1; rdata and fault held stable.
  - Leave only when iwRespReady=1 → IDLE.
  - owReqReady=0, so no new request is accepted in the same cycle.
- Latency from request accepted at posedge N:
  - Response valid from cycle N+2 (normal) or N+1 (fault).
  - Back-to-back throughput: one access per 3 cycles.
- Outside ACCESS, owMemWstrb=0 always.
- owMem*Addr and owMemWriteData stay stable from latch until the next accepted request.
- Reset asserted during ACCESS: strobes drop to 0 immediately and no response is issued. The write is lost if reset precedes the negedge.
- Request inputs are ignored outside IDLE.

Decomposition:
- Package simple_lsu_pkg:
  - funct3 codes (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - FSM state encoding (2 bits).
  - Size codes.
- Sub-module simple_lsu_extend: combinational funct3 + 32-bit word → extended load data.
- Everything else stays in simple_lsu.

Test Plan:
1. SW addr 0x10, data 0xDEADBEEF, then LW 0x10 → write strobe 1111 in ACCESS; load rdata 0xDEADBEEF, fault=0, valid at N+2.
2. SB 0x21 data 0x80, then LB 0x21 and LBU 0x21 → rdata 0xFFFFFF80 and 0x00000080; strobe 0001 only.
3. LH 0x13 and SW 0x22 → fault=1 at N+1, rdata=0, owMemWstrb stays 0000 throughout.
4. LW 0x1FE with pMemBytes=512, then LB 0xFFFFFFFF → both fault (range and wrap); LW 0x1FC → no fault.
5. Hold iwRespReady=0 for 5 cycles in RESP → valid, rdata and fault stable; owReqReady=0; a new iwReqValid is ignored until release.
6. Pull iwnRst low mid-ACCESS of an SW → owMemWstrb=0 and owRespValid=0 immediately; after release, state is IDLE and owReqReady=1.

Source files
------------

// File: rtl/simple_lsu_pkg.sv
// -----------------------------------------------------------------------------
// simple_lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32I load/store funct3 codes
//   - FSM state encoding (2 bits)
//   - access size codes and helpers that derive size / byte strobes from funct3
// -----------------------------------------------------------------------------
package simple_lsu_pkg;

   // Load funct3 codes
   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   // Store funct3 codes
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   // Access size in bytes
   localparam logic [2:0] SIZE_B = 3'd1;
   localparam logic [2:0] SIZE_H = 3'd2;
   localparam logic [2:0] SIZE_W = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_e;

   // Size is carried by funct3[1:0] for both loads and stores.
   // Code 3 is illegal and is rejected separately, so it may map anywhere.
   function automatic logic [2:0] access_size(input logic [1:0] f3_lo);
      logic [2:0] size;
      case (f3_lo)
         2'd0:    size = SIZE_B;
         2'd1:    size = SIZE_H;
         default: size = SIZE_W;
      endcase
      return size;
   endfunction

   function automatic logic [3:0] store_strobe(input logic [1:0] f3_lo);
      logic [3:0] strb;
      case (f3_lo)
         2'd0:    strb = 4'b0001;
         2'd1:    strb = 4'b0011;
         default: strb = 4'b1111;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/simple_lsu_extend.sv
// -----------------------------------------------------------------------------
// simple_lsu_extend
// Combinational load-data extension: selects the byte / half / word from the
// memory word (byte 0 = addressed byte) and sign- or zero-extends it.
// Ports:
//   funct3_i  in  3   load funct3 (LB/LH/LW/LBU/LHU)
//   word_i    in  32  raw memory read data
//   data_o    out 32  extended load data (0 for codes that are not loads)
// -----------------------------------------------------------------------------
module simple_lsu_extend
   import simple_lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [31:0] word_i,
   output logic [31:0] data_o
);

   always_comb begin
      data_o = 32'd0;
      case (funct3_i)
         F3_LB:   data_o = {{24{word_i[7]}}, word_i[7:0]};
         F3_LH:   data_o = {{16{word_i[15]}}, word_i[15:0]};
         F3_LW:   data_o = word_i;
         F3_LBU:  data_o = {24'd0, word_i[7:0]};
         F3_LHU:  data_o = {16'd0, word_i[15:0]};
         default: data_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/simple_lsu.sv
// -----------------------------------------------------------------------------
// simple_lsu
// Load/store unit between the core memory stage and a byte-addressed data
// memory. One request per transaction: IDLE -> ACCESS -> RESP, or IDLE -> RESP
// directly when the request faults (misaligned, out of range, bad funct3).
// Ports:
//   iwClk, iwnRst                 clock, async active-low reset
//   iwReqValid / owReqReady       request handshake (ready only in IDLE)
//   iwReqWrite, iwReqFunct3       store flag, RV32I funct3
//   iwReqAddr, iwReqWdata         byte address, low-aligned store data
//   owRespValid / iwRespReady     response handshake (valid only in RESP)
//   owRespRdata, owRespFault      extended load data, fault flag
//   owMemReadAddr, iwMemReadData  memory read port (combinational data)
//   owMemWriteAddr/Data, owMemWstrb  memory write port; commit on ACCESS negedge
// -----------------------------------------------------------------------------
module simple_lsu
   import simple_lsu_pkg::*;
#(
   parameter logic [31:0] pMemBytes = 32'd512
)(
   input  logic        iwClk,
   input  logic        iwnRst,
   input  logic        iwReqValid,
   output logic        owReqReady,
   input  logic        iwReqWrite,
   input  logic [2:0]  iwReqFunct3,
   input  logic [31:0] iwReqAddr,
   input  logic [31:0] iwReqWdata,
   output logic        owRespValid,
   input  logic        iwRespReady,
   output logic [31:0] owRespRdata,
   output logic        owRespFault,
   output logic [31:0] owMemReadAddr,
   input  logic [31:0] iwMemReadData,
   output logic [31:0] owMemWriteAddr,
   output logic [31:0] owMemWriteData,
   output logic [3:0]  owMemWstrb
);

   lsu_state_e  state_q,  state_d;
   logic        write_q,  write_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q,   addr_d;
   logic [31:0] wdata_q,  wdata_d;
   logic [31:0] rdata_q,  rdata_d;
   logic        fault_q,  fault_d;

   // ---------------------------------------------------------------------
   // Request checks, evaluated on the live request inputs in IDLE
   // ---------------------------------------------------------------------
   logic [2:0]  req_size;
   logic        req_illegal;
   logic        req_misaligned;
   logic        req_out_of_range;
   logic        req_fault;
   logic [32:0] req_end;

   assign req_size = access_size(iwReqFunct3[1:0]);

   // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
   assign req_illegal = iwReqWrite ? (iwReqFunct3 >= 3'd3)
                                   : ((iwReqFunct3 == 3'd3) || (iwReqFunct3 >= 3'd6));

   assign req_misaligned = ((req_size != SIZE_B) && iwReqAddr[0]) ||
                           ((req_size == SIZE_W) && iwReqAddr[1]);

   // 33-bit sum so an address near 2^32 cannot wrap into the legal range.
   assign req_end          = {1'b0, iwReqAddr} + {30'd0, req_size};
   assign req_out_of_range = req_end > {1'b0, pMemBytes};

   assign req_fault = req_illegal || req_misaligned || req_out_of_range;

   // ---------------------------------------------------------------------
   // Load data extension
   // ---------------------------------------------------------------------
   logic [31:0] ext_data;

   simple_lsu_extend u_extend (
      .funct3_i (funct3_q),
      .word_i   (iwMemReadData),
      .data_o   (ext_data)
   );

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge iwClk or negedge iwnRst) begin
      if (!iwnRst) begin
         state_q  <= ST_IDLE;
         write_q  <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      fault_d     = fault_q;
      owReqReady  = 1'b0;
      owRespValid = 1'b0;
      owMemWstrb  = 4'b0000;

      case (state_q)
         ST_IDLE: begin
            owReqReady = 1'b1;
            if (iwReqValid) begin
               write_d  = iwReqWrite;
               funct3_d = iwReqFunct3;
               addr_d   = iwReqAddr;
               wdata_d  = iwReqWdata;
               rdata_d  = 32'd0;
               fault_d  = req_fault;
               state_d  = req_fault ? ST_RESP : ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            // Decoded only from registered state so the strobes cannot
            // glitch before the memory commits on the falling edge.
            if (write_q) begin
               owMemWstrb = store_strobe(funct3_q[1:0]);
            end
            rdata_d = write_q ? 32'd0 : ext_data;
            state_d = ST_RESP;
         end

         ST_RESP: begin
            owRespValid = 1'b1;
            if (iwRespReady) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign owRespRdata    = rdata_q;
   assign owRespFault    = fault_q;
   assign owMemReadAddr  = addr_q;
   assign owMemWriteAddr = addr_q;
   assign owMemWriteData = wdata_q;

endmodule

// File: tb/tb_simple_lsu.sv
// -----------------------------------------------------------------------------
// tb_simple_lsu
// Directed bench for simple_lsu with a 512-byte behavioural memory that
// commits writes on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_simple_lsu;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;

   int n_checks = 0;
   int n_fail   = 0;

   simple_lsu #(.pMemBytes(32'd512)) dut (
      .iwClk          (clk),
      .iwnRst         (rst_n),
      .iwReqValid     (req_valid),
      .owReqReady     (req_ready),
      .iwReqWrite     (req_write),
      .iwReqFunct3    (req_funct3),
      .iwReqAddr      (req_addr),
      .iwReqWdata     (req_wdata),
      .owRespValid    (resp_valid),
      .iwRespReady    (resp_ready),
      .owRespRdata    (resp_rdata),
      .owRespFault    (resp_fault),
      .owMemReadAddr  (mem_raddr),
      .iwMemReadData  (mem_rdata),
      .owMemWriteAddr (mem_waddr),
      .owMemWriteData (mem_wdata),
      .owMemWstrb     (mem_wstrb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural memory: combinational read, byte-strobed write on negedge.
   logic [7:0] mem [0:511];
   int         strobe_events = 0;
   logic [3:0] last_strobe   = 4'b0000;

   assign mem_rdata = {mem[9'(mem_raddr + 32'd3)], mem[9'(mem_raddr + 32'd2)],
                       mem[9'(mem_raddr + 32'd1)], mem[9'(mem_raddr)]};

   always @(negedge clk) begin
      if (mem_wstrb != 4'b0000) begin
         strobe_events = strobe_events + 1;
         last_strobe   = mem_wstrb;
         for (int i = 0; i < 4; i++) begin
            if (mem_wstrb[i]) mem[9'(mem_waddr + 32'(i))] = mem_wdata[8*i +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction, entered and left at posedge+1 in IDLE.
   task automatic txn(input string tag, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic exp_fault, input logic [31:0] exp_rdata,
                      input logic [3:0] exp_strobe);
      int ev0;
      ev0        = strobe_events;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = d;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      chk({tag, "/ready_busy"}, 32'(req_ready), 32'd0);
      chk({tag, "/latched_addr"}, mem_raddr, a);
      if (!exp_fault) begin
         chk({tag, "/valid_early"}, 32'(resp_valid), 32'd0);
         @(posedge clk); #1;
      end
      chk({tag, "/valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "/rdata"}, resp_rdata, exp_rdata);
      chk({tag, "/fault"}, 32'(resp_fault), 32'(exp_fault));
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk({tag, "/valid_drop"}, 32'(resp_valid), 32'd0);
      chk({tag, "/ready_back"}, 32'(req_ready), 32'd1);
      chk({tag, "/strobe_cnt"}, 32'(strobe_events - ev0), (exp_strobe != 4'b0000) ? 32'd1 : 32'd0);
      if (exp_strobe != 4'b0000) chk({tag, "/strobe"}, 32'(last_strobe), 32'(exp_strobe));
      $display("txn %s: w=%0b f3=%0d addr=%h rdata=%h fault=%0b", tag, w, f3, a, resp_rdata, resp_fault);
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      resp_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset/resp_valid", 32'(resp_valid), 32'd0);
      chk("reset/rdata",      resp_rdata,       32'd0);
      chk("reset/fault",      32'(resp_fault), 32'd0);
      chk("reset/wstrb",      32'(mem_wstrb),  32'd0);
      chk("reset/ready",      32'(req_ready),  32'd1);
      chk("reset/addr",       mem_waddr,        32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Word store then load back
      txn("sw_10",  1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        4'b1111);
      txn("lw_10",  1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 4'b0000);

      // Byte store, signed and unsigned byte loads
      txn("sb_21",  1'b1, 3'd0, 32'h21, 32'h00000080, 1'b0, 32'h0,        4'b0001);
      txn("lb_21",  1'b0, 3'd0, 32'h21, 32'h0,        1'b0, 32'hFFFFFF80, 4'b0000);
      txn("lbu_21", 1'b0, 3'd4, 32'h21, 32'h0,        1'b0, 32'h00000080, 4'b0000);

      // Half store only touches the low two bytes
      txn("sw_30",  1'b1, 3'd2, 32'h30, 32'hFFFFFFFF, 1'b0, 32'h0,        4'b1111);
      txn("sh_30",  1'b1, 3'd1, 32'h30, 32'hABCD9234, 1'b0, 32'h0,        4'b0011);
      txn("lh_30",  1'b0, 3'd1, 32'h30, 32'h0,        1'b0, 32'hFFFF9234, 4'b0000);
      txn("lhu_30", 1'b0, 3'd5, 32'h30, 32'h0,        1'b0, 32'h00009234, 4'b0000);
      txn("lw_30",  1'b0, 3'd2, 32'h30, 32'h0,        1'b0, 32'hFFFF9234, 4'b0000);

      // Misalignment and illegal funct3: fault, no strobes
      txn("lh_13",  1'b0, 3'd1, 32'h13, 32'h0,        1'b1, 32'h0,        4'b0000);
      txn("sw_22",  1'b1, 3'd2, 32'h22, 32'h12345678, 1'b1, 32'h0,        4'b0000);
      txn("ld_f3",  1'b0, 3'd3, 32'h10, 32'h0,        1'b1, 32'h0,        4'b0000);
      txn("st_f4",  1'b1, 3'd4, 32'h10, 32'h0,        1'b1, 32'h0,        4'b0000);
      txn("ld_f6",  1'b0, 3'd6, 32'h10, 32'h0,        1'b1, 32'h0,        4'b0000);

      // Range boundaries and wrap-around
      txn("lw_1fe", 1'b0, 3'd2, 32'h1FE,      32'h0,  1'b1, 32'h0,        4'b0000);
      txn("lb_wrap",1'b0, 3'd0, 32'hFFFFFFFF, 32'h0,  1'b1, 32'h0,        4'b0000);
      txn("lb_200", 1'b0, 3'd0, 32'h200,      32'h0,  1'b1, 32'h0,        4'b0000);
      txn("sw_1fc", 1'b1, 3'd2, 32'h1FC, 32'hCAFEF00D, 1'b0, 32'h0,       4'b1111);
      txn("lw_1fc", 1'b0, 3'd2, 32'h1FC, 32'h0,       1'b0, 32'hCAFEF00D, 4'b0000);
      txn("lhu_1fe",1'b0, 3'd5, 32'h1FE, 32'h0,       1'b0, 32'h0000CAFE, 4'b0000);

      // Response back-pressure: RESP held, new request ignored
      req_write  = 1'b0;
      req_funct3 = 3'd2;
      req_addr   = 32'h10;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      @(posedge clk); #1;
      req_write  = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = 32'h50;
      req_wdata  = 32'h55555555;
      req_valid  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("hold/valid", 32'(resp_valid), 32'd1);
         chk("hold/rdata", resp_rdata,       32'hDEADBEEF);
         chk("hold/fault", 32'(resp_fault), 32'd0);
         chk("hold/ready", 32'(req_ready),  32'd0);
         chk("hold/wstrb", 32'(mem_wstrb),  32'd0);
         $display("hold cycle %0d: valid=%0b rdata=%h ready=%0b", c, resp_valid, resp_rdata, req_ready);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      chk("hold/released_valid", 32'(resp_valid), 32'd0);
      chk("hold/released_ready", 32'(req_ready),  32'd1);
      chk("hold/addr_unchanged", mem_raddr,        32'h10);

      // Reset in the middle of a store's ACCESS cycle
      txn("sw_40",  1'b1, 3'd2, 32'h40, 32'h11111111, 1'b0, 32'h0,        4'b1111);
      req_write  = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = 32'h40;
      req_wdata  = 32'h12345678;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      chk("rst_mid/wstrb_access", 32'(mem_wstrb), 32'hF);
      rst_n = 1'b0;
      #1;
      chk("rst_mid/wstrb_drop",  32'(mem_wstrb),  32'd0);
      chk("rst_mid/resp_valid",  32'(resp_valid), 32'd0);
      $display("reset mid-access: wstrb=%b resp_valid=%0b", mem_wstrb, resp_valid);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid/ready",       32'(req_ready),  32'd1);
      chk("rst_mid/valid_after", 32'(resp_valid), 32'd0);
      txn("lw_40",  1'b0, 3'd2, 32'h40, 32'h0,        1'b0, 32'h11111111, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
